// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the multiplexed time display:
// segment glyphs, digit-slot map and enable helper.
package seg_scan_display_pkg;

    // Active-low glyphs {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0    = 7'h40;
    localparam logic [6:0] GLYPH_1    = 7'h79;
    localparam logic [6:0] GLYPH_2    = 7'h24;
    localparam logic [6:0] GLYPH_3    = 7'h30;
    localparam logic [6:0] GLYPH_4    = 7'h19;
    localparam logic [6:0] GLYPH_5    = 7'h12;
    localparam logic [6:0] GLYPH_6    = 7'h02;
    localparam logic [6:0] GLYPH_7    = 7'h78;
    localparam logic [6:0] GLYPH_8    = 7'h00;
    localparam logic [6:0] GLYPH_9    = 7'h10;
    localparam logic [6:0] GLYPH_E    = 7'h06;
    localparam logic [6:0] GLYPH_DASH = 7'h3F;

    // Full 8-bit patterns {dp,g..a}
    localparam logic       DP_OFF   = 1'b1;
    localparam logic [7:0] SEG_DASH = {DP_OFF, GLYPH_DASH};
    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] AN_OFF   = 8'hFF;

    // Digit slots, right to left on the display
    localparam logic [2:0] SLOT_SEC_U  = 3'd0;
    localparam logic [2:0] SLOT_SEC_T  = 3'd1;
    localparam logic [2:0] SLOT_DASH_L = 3'd2;
    localparam logic [2:0] SLOT_MIN_U  = 3'd3;
    localparam logic [2:0] SLOT_MIN_T  = 3'd4;
    localparam logic [2:0] SLOT_DASH_H = 3'd5;
    localparam logic [2:0] SLOT_HOUR_U = 3'd6;
    localparam logic [2:0] SLOT_HOUR_T = 3'd7;
    localparam logic [2:0] SLOT_LAST   = 3'd7;

    // One-hot active-low digit enable for a slot
    function automatic logic [7:0] slot_enable(input logic [2:0] slot);
        return ~(8'h01 << slot);
    endfunction

endpackage

// File: rtl/seg_scan_display_seg7_decode.sv
// BCD nibble to active-low 7-segment glyph.
// Nibbles 10-15 render as 'E'.
module seg7_decode
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] glyph
);

    // Pure lookup; out-of-range codes show an error glyph
    always_comb begin
        glyph = GLYPH_E;
        unique case (bcd)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = GLYPH_E;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed HH-MM-SS display scanner
// with frame-aligned shadow capture and chime buzzer.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int BUZZ_DIV = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       blank,
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    input  logic       tweet,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       buzz
);

    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BUZZ_DIV > 2) ? $clog2(BUZZ_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] TONE_LAST = BW'(BUZZ_DIV - 1);

    logic [SW-1:0] scan_cnt;
    logic          tick;
    logic [2:0]    idx;
    logic          frame_wrap;
    logic [7:0]    sh_hour;
    logic [7:0]    sh_min;
    logic [7:0]    sh_sec;
    logic [3:0]    nib;
    logic          dash;
    logic [6:0]    glyph;
    logic [BW-1:0] tone_cnt;
    logic          tweet_q;

    assign tick       = (scan_cnt == SCAN_LAST);
    assign frame_wrap = tick && (idx == SLOT_LAST);

    // Slot-period prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
        end else if (tick) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Digit slot index, wraps 7 -> 0 naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= idx + 3'd1;
        end
    end

    // Time snapshot taken once per frame so digits never tear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_hour <= '0;
            sh_min  <= '0;
            sh_sec  <= '0;
        end else if (frame_wrap) begin
            sh_hour <= hour;
            sh_min  <= min;
            sh_sec  <= sec;
        end
    end

    // Pick the nibble (or dash) shown in the current slot
    always_comb begin
        nib  = '0;
        dash = 1'b0;
        unique case (idx)
            SLOT_SEC_U:  nib = sh_sec[3:0];
            SLOT_SEC_T:  nib = sh_sec[7:4];
            SLOT_DASH_L: dash = 1'b1;
            SLOT_MIN_U:  nib = sh_min[3:0];
            SLOT_MIN_T:  nib = sh_min[7:4];
            SLOT_DASH_H: dash = 1'b1;
            SLOT_HOUR_U: nib = sh_hour[3:0];
            SLOT_HOUR_T: nib = sh_hour[7:4];
        endcase
    end

    seg7_decode u_decode (
        .bcd   (nib),
        .glyph (glyph)
    );

    // Registered drive lags the index by one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else if (blank) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= slot_enable(idx);
            seg <= dash ? SEG_DASH : {DP_OFF, glyph};
        end
    end

    // Chime tone: restart phase on request edge, silence when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tweet_q  <= 1'b0;
            tone_cnt <= '0;
            buzz     <= 1'b0;
        end else begin
            tweet_q <= tweet;
            if (!tweet || !tweet_q) begin
                tone_cnt <= '0;
                buzz     <= 1'b0;
            end else if (tone_cnt == TONE_LAST) begin
                tone_cnt <= '0;
                buzz     <= ~buzz;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
            end
        end
    end

endmodule
